// File: rtl/pfpu_dma_out.sv
// pfpu_dma_out: vertex-output DMA that writes two-word results into a raster-ordered mesh buffer over Wishbone.
// Optional stall statistics are enabled by defining PFPU_DMA_STATS_EN.
module pfpu_dma_out #(
  parameter int DEPTH     = 8,
  parameter int MESH_BITS = 7
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     start,
  input  logic [28:0]              dma_base,
  input  logic [MESH_BITS-1:0]     hmesh_last,
  input  logic [MESH_BITS-1:0]     vmesh_last,
  input  logic                     vtx_valid,
  output logic                     vtx_ready,
  input  logic [31:0]              vtx_a,
  input  logic [31:0]              vtx_b,
  output logic [31:0]              wbm_adr_o,
  output logic [31:0]              wbm_dat_o,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  input  logic                     wbm_ack_i,
  output logic                     busy,
  output logic                     done,
  output logic [2*MESH_BITS-1:0]   vertex_cnt,
  output logic [15:0]              stray_cnt,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [31:0]              stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = 2*MESH_BITS+1;
  typedef enum logic [1:0] {IDLE, RUN, WR0, WR1} state_t;
  state_t state;
  logic [63:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic [28:0] base;
  logic [MESH_BITS-1:0] hl, vl, x, y, nx, ny, ax, ay;
  logic [CW-1:0] acc_cnt, total;
  logic [31:0] b_reg, a_next;
  logic [63:0] head;
  logic full, empty, acc_done, push, pop, go, ack1, last, wrap_x;
  // FIFO status, input handshake and the address of the next vertex to be written
  always_comb begin
    pending   = wp - rp;
    full      = pending == (AW+1)'(DEPTH);
    empty     = wp == rp;
    total     = (CW'(hl) + CW'(1)) * (CW'(vl) + CW'(1));
    acc_done  = acc_cnt == total;
    vtx_ready = busy & ~full & ~acc_done;
    push      = vtx_valid & vtx_ready;
    go        = (state == IDLE) & start;
    ack1      = (state == WR1) & wbm_ack_i;
    last      = (x == hl) & (y == vl);
    wrap_x    = x == hl;
    nx        = wrap_x ? '0 : x + 1'b1;
    ny        = wrap_x ? y + 1'b1 : y;
    pop       = ~empty & ((state == RUN) | (ack1 & ~last));
    ax        = (state == WR1) ? nx : x;
    ay        = (state == WR1) ? ny : y;
    a_next    = {base, 3'b0} + (32'(ay) << (MESH_BITS+3)) + (32'(ax) << 3);
    head      = mem[rp[AW-1:0]];
  end
  // FIFO storage holds {vtx_b, vtx_a}; no reset needed since pointers gate validity
  always_ff @(posedge sys_clk) begin
    if (push) mem[wp[AW-1:0]] <= {vtx_b, vtx_a};
  end
  // FIFO pointers, accepted-vertex count and saturating stray counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wp        <= '0;
      rp        <= '0;
      acc_cnt   <= '0;
      stray_cnt <= '0;
    end else begin
      wp        <= wp + (AW+1)'(push);
      rp        <= rp + (AW+1)'(pop);
      acc_cnt   <= go ? '0 : acc_cnt + CW'(push);
      stray_cnt <= go ? '0 : stray_cnt + 16'(vtx_valid & (~busy | acc_done) & ~&stray_cnt);
    end
  end
  // Write sequencer: each vertex becomes two single writes, back-to-back when more data is queued
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      base       <= '0;
      hl         <= '0;
      vl         <= '0;
      x          <= '0;
      y          <= '0;
      vertex_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      b_reg      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          base       <= dma_base;
          hl         <= hmesh_last;
          vl         <= vmesh_last;
          x          <= '0;
          y          <= '0;
          vertex_cnt <= '0;
          busy       <= 1'b1;
          state      <= RUN;
        end
        RUN: if (pop) begin
          state     <= WR0;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wbm_adr_o <= a_next;
          wbm_dat_o <= head[31:0];
          b_reg     <= head[63:32];
        end
        WR0: if (wbm_ack_i) begin
          state     <= WR1;
          wbm_adr_o <= wbm_adr_o + 32'd4;
          wbm_dat_o <= b_reg;
        end
        WR1: if (wbm_ack_i) begin
          x          <= nx;
          y          <= ny;
          vertex_cnt <= vertex_cnt + 1'b1;
          if (last) begin
            state     <= IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (pop) begin
            state     <= WR0;
            wbm_adr_o <= a_next;
            wbm_dat_o <= head[31:0];
            b_reg     <= head[63:32];
          end else begin
            state     <= RUN;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PFPU_DMA_STATS_EN
  // Saturating count of strobe cycles the slave has not yet acknowledged
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) stall_cnt <= '0;
    else stall_cnt <= go ? '0 : stall_cnt + 32'(wbm_stb_o & ~wbm_ack_i & ~&stall_cnt);
  end
`else
  assign stall_cnt = '0;
`endif
endmodule
